// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums groups of signed products from the sequential multiplier into a
//   saturating dot-product result. A group closes after N_TERMS products,
//   or earlier when src_last is set on the handshake.
//
// Ports:
//   clk        - clock; all logic runs on the rising edge
//   rst_n      - synchronous active-low reset
//   product    - signed product from the multiplier (2*WIDTH bits)
//   src_last   - final product of a group; sampled only on an input handshake
//   src_valid  - product valid (from the multiplier's dest_valid)
//   src_ready  - accumulator can accept (to the multiplier's dest_ready)
//   acc_out    - signed group sum (OUT_WIDTH bits)
//   term_count - number of products in the group
//   sat_flag   - the group sum was clamped at least once
//   dest_valid - result valid
//   dest_ready - downstream accepts the result
module product_accumulator #(
  parameter int WIDTH     = 16,
  parameter int N_TERMS   = 4,
  parameter int OUT_WIDTH = 2*WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*WIDTH-1:0]           product,
  input  logic                         src_last,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic [OUT_WIDTH-1:0]         acc_out,
  output logic [$clog2(N_TERMS+1)-1:0] term_count,
  output logic                         sat_flag,
  output logic                         dest_valid,
  input  logic                         dest_ready
);

  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(N_TERMS+1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                 state;
  logic [OUT_WIDTH-1:0]   acc;
  logic [CW-1:0]          cnt;
  logic                   sat_sticky;

  logic [OUT_WIDTH:0]     sum_wide;
  logic [OUT_WIDTH-1:0]   sum_clamped;
  logic                   clamp_now;
  logic [CW-1:0]          cnt_inc;
  logic                   closing;
  logic                   handshake;

  // The state alone decides src_ready; it never depends on src_valid.
  assign src_ready = (state == ACCUM);
  assign handshake = src_valid & src_ready;

  // The sum is one bit wider than the accumulator. If its top two bits
  // differ, the true result is outside the OUT_WIDTH range. The top bit
  // then gives the direction of the overflow.
  always_comb begin
    sum_wide    = {acc[OUT_WIDTH-1], acc}
                + {{(OUT_WIDTH+1-PW){product[PW-1]}}, product};
    clamp_now   = sum_wide[OUT_WIDTH] != sum_wide[OUT_WIDTH-1];
    sum_clamped = sum_wide[OUT_WIDTH-1:0];
    if (clamp_now) begin
      if (sum_wide[OUT_WIDTH]) begin
        sum_clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        sum_clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
    cnt_inc = cnt + 1'b1;
    closing = src_last || (cnt_inc == CW'(N_TERMS));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
      acc_out    <= '0;
      term_count <= '0;
      sat_flag   <= 1'b0;
      dest_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (handshake) begin
            if (closing) begin
              acc_out    <= sum_clamped;
              term_count <= cnt_inc;
              sat_flag   <= sat_sticky | clamp_now;
              dest_valid <= 1'b1;
              acc        <= '0;
              cnt        <= '0;
              sat_sticky <= 1'b0;
              state      <= HOLD;
            end else begin
              acc        <= sum_clamped;
              cnt        <= cnt_inc;
              sat_sticky <= sat_sticky | clamp_now;
            end
          end
        end
        HOLD: begin
          // The result registers keep their value after the handshake.
          if (dest_ready) begin
            dest_valid <= 1'b0;
            state      <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the sequential multiplier's product stream; sums groups of signed products into a dot-product result.
- Input side is a valid/ready slave that connects directly to the multiplier's dest_valid/dest_ready/product.
- Output side is a valid/ready master carrying the group sum, the term count and a saturation flag.
- A group closes after N_TERMS products or early on src_last.

Parameters:
- WIDTH, 16, multiplier operand width; incoming product is 2*WIDTH bits signed.
- N_TERMS, 4, maximum products per group (>=1).
- OUT_WIDTH, 2*WIDTH, accumulator/result width, signed, must be >= 2*WIDTH.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- product  input  2*WIDTH  signed product from multiplier
- src_last  input  1  marks final product of a group; sampled only on input handshake
- src_valid  input  1  product valid (from multiplier dest_valid)
- src_ready  output  1  accumulator can accept (to multiplier dest_ready)
- acc_out  output  OUT_WIDTH  signed group sum
- term_count  output  $clog2(N_TERMS+1)  number of products in the group
- sat_flag  output  1  group sum clamped at least once
- dest_valid  output  1  result valid
- dest_ready  input  1  downstream accepts result

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge):
  - state=ACCUM, internal acc=0, cnt=0, sticky sat=0.
  - acc_out=0, term_count=0, sat_flag=0, dest_valid=0.
  - src_ready=1 from the first cycle after reset.
- States:
  - ACCUM: src_ready=1, dest_valid=0.
  - HOLD: src_ready=0, dest_valid=1. src_ready is decoded from the state only and never depends on src_valid.
- Input handshake: src_valid & src_ready at a clk edge.
  - sum = acc + sign_extend(product) computed in OUT_WIDTH+1 bits.
  - If sum > 2^(OUT_WIDTH-1)-1, clamp to max. If sum < -2^(OUT_WIDTH-1), clamp to min. Either clamp sets sticky sat.
  - After a clamp, accumulation continues from the clamped value.
- Group close: on a handshake where cnt+1==N_TERMS or src_last=1.
  - acc_out <= clamped sum, term_count <= cnt+1, sat_flag <= sticky sat | clamp-this-cycle, dest_valid <= 1.
  - acc, cnt and sticky sat clear; state -> HOLD.
  - dest_valid rises the cycle after the closing handshake (latency 1).
- Any other handshake: acc <= clamped sum, cnt <= cnt+1, state stays ACCUM.
- No handshake: all registers hold; product and src_last are don't-care.
- HOLD:
  - acc_out, term_count and sat_flag stay stable while dest_valid=1 and dest_ready=0.
  - src_valid is ignored.
  - On dest_valid & dest_ready: dest_valid <= 0, state -> ACCUM, src_ready=1 the next cycle.
  - Outputs retain their last value after dest_valid falls.
- Throughput: one result per group; one-cycle src bubble minimum per group.
- N_TERMS=1: every handshake closes a group.
- src_last together with cnt+1==N_TERMS closes exactly one group (no double emit).
- Reset during ACCUM or HOLD discards the partial sum and any pending result; no dest_valid pulse follows.

Test Plan:
1. Reset, then products 10, 20, -5, 7 with src_last=0 -> dest_valid=1 one cycle after the 4th handshake; acc_out=32, term_count=4, sat_flag=0.
2. Products 100, then -300 with src_last=1 -> acc_out=-200, term_count=2, sat_flag=0; next group starts from 0.
3. Four products of 1073741824 (32768*32768) -> 2nd add clamps; acc_out=2147483647, sat_flag=1, term_count=4.
4. Products -1073741824 x4 -> 3rd add clamps; acc_out=-2147483648, sat_flag=1; following group 1, 2, 3, 4 -> acc_out=10, sat_flag=0.
5. Hold dest_ready=0 for 5 cycles after a result while src_valid=1 with product 999 -> dest_valid, acc_out and term_count stable, src_ready=0, 999 not accumulated; dest_ready=1 -> dest_valid falls next cycle, src_ready=1.
6. Two handshakes (5, 6), then rst_n=0 for 1 cycle, then 1, 2, 3, 4 -> acc_out=10, term_count=4; no result emitted for the discarded partial group.
